kernel_channel_acc_pe: RTL and testbench
========================================

Name: kernel_channel_acc_pe

Overview:
- Parametrised next-generation kernel/channel MAC array.
- Each accepted beat computes, for every one of NUM_KERNEL kernels, the dot product of NUM_CHANNEL data bytes with that kernel's NUM_CHANNEL weights.
- Accumulates the result over a configurable number of beats (channel groups) on top of an injected bias/psum.
- Emits all kernel psums together through a valid/ready output handshake.
- Sits between the line-buffer/weight feeders and the psum writeback stage.

Parameters:
BIT_WIDTH, 8, data/weight element width
NUM_CHANNEL, 3, channels per beat (≥1)
NUM_KERNEL, 4, kernels computed in parallel (≥1)
PSUM_WIDTH, 24, per-kernel accumulator/output width (≥2*BIT_WIDTH+clog2(NUM_CHANNEL))
ACC_LEN_WIDTH, 8, width of accumulation-length config
REG_WIDTH, 32, error register width

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
i_data  in  BIT_WIDTH*NUM_CHANNEL  channel c at bits [c*BIT_WIDTH +: BIT_WIDTH]
i_data_vld  in  1  data valid
i_weight  in  BIT_WIDTH*NUM_CHANNEL*NUM_KERNEL  kernel k, channel c at [(k*NUM_CHANNEL+c)*BIT_WIDTH +: BIT_WIDTH]
i_weight_vld  in  1  weight valid
i_psum  in  PSUM_WIDTH*NUM_KERNEL  per-kernel initial psum/bias, kernel k at [k*PSUM_WIDTH +: PSUM_WIDTH]
i_conf_neg_enb  in  1  1 = signed two's-complement operands, 0 = unsigned
i_conf_acc_len  in  ACC_LEN_WIDTH  beats per output group; 0 treated as 1
o_in_rdy  out  1  block accepts a beat this cycle
o_psum  out  PSUM_WIDTH*NUM_KERNEL  accumulated psums, same packing as i_psum
o_psum_vld  out  1  o_psum valid
i_psum_rdy  in  1  downstream accepts o_psum
err_psum_vld  out  REG_WIDTH  sticky error flags

Behaviour:
- Reset (async, rst=1): FSM→IDLE; accumulators, pipeline registers, beat counter cleared; o_psum=0, o_psum_vld=0, o_in_rdy=0 while rst high, err_psum_vld=0. Reset mid-group discards all partial state.
- Beat accepted on a rising edge when i_data_vld & i_weight_vld & o_in_rdy.
- Arithmetic: neg_enb=1 sign-extends operands, 0 zero-extends. Products are summed across channels, then extended to PSUM_WIDTH. i_psum is taken as-is at PSUM_WIDTH. All accumulation wraps modulo 2^PSUM_WIDTH; no saturation.
- Pipeline per beat:
  - S1: products registered at the accept edge.
  - S2: channel sum registered on the next edge.
  - ACC: accumulator += S2 on the following edge.
- FSM:
  - IDLE: o_in_rdy=1. On first accepted beat: load accumulator with i_psum; latch neg_enb and acc_len (held for the group); beat count=1. Go to ACCUM if latched len>1, else DRAIN.
  - ACCUM: o_in_rdy=1. Each accepted beat increments count. When count reaches len, go to DRAIN. Idle cycles (no beat) are allowed; no timeout.
  - DRAIN: o_in_rdy=0 for 3 cycles while the pipeline flushes into the accumulator; then copy accumulator to o_psum and go to OUT.
  - OUT: o_psum_vld=1, o_psum held stable, o_in_rdy=0. On i_psum_rdy=1: o_psum_vld drops next cycle, FSM→IDLE (o_in_rdy=1 that cycle). o_psum keeps its last value after handshake.
- Latency: o_psum_vld rises 4 cycles after the edge accepting the final beat of a group.
- Throughput: acc_len + 5 cycles per group with i_psum_rdy held high.
- Config changes mid-group are ignored until the next IDLE.
- err_psum_vld (sticky, cleared only by reset):
  - bit0: cycle with i_data_vld≠i_weight_vld while o_in_rdy=1.
  - bit1: i_data_vld&i_weight_vld while o_in_rdy=0 (beat dropped; no state change).
  - remaining bits 0.

Test Plan:
- Unsigned, len=1, data={3,2,1} (ch2..ch0), weights k0={1,1,1}, k1={2,2,2}, k2={0,0,0}, k3={255,255,255}, i_psum k0=10, others 0 → o_psum k0=16, k1=12, k2=0, k3=1530; o_psum_vld 4 cycles after accept.
- Signed, len=1, all data 0xFF (−1), all weights 0x02, i_psum=−4 (0xFFFFFC) → every kernel 0xFFFFF6 (−10).
- len=4, data {1,2,3}, weights all 1 each beat, bias 5, beats with 1-cycle gaps → 29 per kernel; o_in_rdy low from DRAIN until handshake.
- Wrap: unsigned, all operands 255, len=100, bias 0 → 19,507,500 mod 2^24 = 2,730,284.
- Backpressure: i_psum_rdy low 5 cycles in OUT → o_psum stable, o_psum_vld high; a beat driven then sets err bit1 and does not alter result. Mismatched valid (data_vld=1, weight_vld=0) in IDLE → err bit0.
- Assert rst asynchronously mid-ACCUM (between clock edges) → outputs and err clear immediately. After release, a fresh len=1 group produces a result with no residue from the aborted group.

Source files
------------

// File: rtl/kernel_channel_acc_pe.sv
// Kernel x channel MAC array: per beat, NUM_KERNEL dot products over NUM_CHANNEL bytes,
// accumulated over acc_len beats on top of an injected bias, then handed out via valid/ready.
module kernel_channel_acc_pe #(
  parameter int BIT_WIDTH     = 8,
  parameter int NUM_CHANNEL   = 3,
  parameter int NUM_KERNEL    = 4,
  parameter int PSUM_WIDTH    = 24,
  parameter int ACC_LEN_WIDTH = 8,
  parameter int REG_WIDTH     = 32
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [BIT_WIDTH*NUM_CHANNEL-1:0]          i_data,
  input  logic                                      i_data_vld,
  input  logic [BIT_WIDTH*NUM_CHANNEL*NUM_KERNEL-1:0] i_weight,
  input  logic                                      i_weight_vld,
  input  logic [PSUM_WIDTH*NUM_KERNEL-1:0]          i_psum,
  input  logic                                      i_conf_neg_enb,
  input  logic [ACC_LEN_WIDTH-1:0]                  i_conf_acc_len,
  output logic                                      o_in_rdy,
  output logic [PSUM_WIDTH*NUM_KERNEL-1:0]          o_psum,
  output logic                                      o_psum_vld,
  input  logic                                      i_psum_rdy,
  output logic [REG_WIDTH-1:0]                      err_psum_vld
);

  // One extra bit per operand holds the sign (or a zero for unsigned mode).
  localparam int PROD_W = 2*BIT_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

  state_t                   state, state_nxt;
  logic                     accept;
  logic                     neg_q, neg_cur;
  logic [ACC_LEN_WIDTH-1:0] len_q, len_in, beat_cnt;
  logic [1:0]               drain_cnt;
  logic                     s1_vld, s2_vld;
  logic [1:0]               err_q;

  logic signed [PROD_W-1:0]     prod   [NUM_KERNEL][NUM_CHANNEL];
  logic signed [PROD_W-1:0]     prod_q [NUM_KERNEL][NUM_CHANNEL];
  logic        [PSUM_WIDTH-1:0] sum    [NUM_KERNEL];
  logic        [PSUM_WIDTH-1:0] sum_q  [NUM_KERNEL];
  logic        [PSUM_WIDTH-1:0] acc    [NUM_KERNEL];

  function automatic logic signed [BIT_WIDTH:0] ext_op(input logic [BIT_WIDTH-1:0] v,
                                                       input logic neg);
    return {neg & v[BIT_WIDTH-1], v};
  endfunction

  assign accept  = i_data_vld & i_weight_vld & o_in_rdy;
  assign len_in  = (i_conf_acc_len == '0) ? {{(ACC_LEN_WIDTH-1){1'b0}}, 1'b1} : i_conf_acc_len;
  // The first beat of a group is multiplied before the config is latched.
  assign neg_cur = (state == IDLE) ? i_conf_neg_enb : neg_q;

  always_comb begin
    for (int k = 0; k < NUM_KERNEL; k++) begin
      for (int c = 0; c < NUM_CHANNEL; c++) begin
        prod[k][c] = PROD_W'(ext_op(i_data[c*BIT_WIDTH +: BIT_WIDTH], neg_cur))
                   * PROD_W'(ext_op(i_weight[(k*NUM_CHANNEL+c)*BIT_WIDTH +: BIT_WIDTH], neg_cur));
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_KERNEL; k++) begin
      sum[k] = '0;
      for (int c = 0; c < NUM_CHANNEL; c++) begin
        sum[k] = sum[k] + PSUM_WIDTH'(prod_q[k][c]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = (len_in > 1) ? ACCUM : DRAIN;
      ACCUM: if (accept && (beat_cnt + 1'b1 == len_q)) state_nxt = DRAIN;
      DRAIN: if (drain_cnt == 2'd3) state_nxt = OUT;
      OUT:   if (i_psum_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_in_rdy   = ~rst & ((state == IDLE) || (state == ACCUM));
    o_psum_vld = (state == OUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_q     <= 1'b0;
      len_q     <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      s1_vld    <= 1'b0;
      s2_vld    <= 1'b0;
      o_psum    <= '0;
      for (int k = 0; k < NUM_KERNEL; k++) begin
        sum_q[k] <= '0;
        acc[k]   <= '0;
        for (int c = 0; c < NUM_CHANNEL; c++) prod_q[k][c] <= '0;
      end
    end else begin
      s1_vld <= accept;
      s2_vld <= s1_vld;
      if (accept) begin
        for (int k = 0; k < NUM_KERNEL; k++)
          for (int c = 0; c < NUM_CHANNEL; c++) prod_q[k][c] <= prod[k][c];
      end
      if (s1_vld) begin
        for (int k = 0; k < NUM_KERNEL; k++) sum_q[k] <= sum[k];
      end

      if (state == IDLE && accept) begin
        neg_q    <= i_conf_neg_enb;
        len_q    <= len_in;
        beat_cnt <= {{(ACC_LEN_WIDTH-1){1'b0}}, 1'b1};
        for (int k = 0; k < NUM_KERNEL; k++) acc[k] <= i_psum[k*PSUM_WIDTH +: PSUM_WIDTH];
      end else begin
        if (accept) beat_cnt <= beat_cnt + 1'b1;
        if (s2_vld) begin
          for (int k = 0; k < NUM_KERNEL; k++) acc[k] <= acc[k] + sum_q[k];
        end
      end

      // Last beat lands in acc two edges after acceptance; the fourth drain edge publishes it.
      if (state == DRAIN) begin
        drain_cnt <= drain_cnt + 2'd1;
        if (drain_cnt == 2'd3) begin
          for (int k = 0; k < NUM_KERNEL; k++) o_psum[k*PSUM_WIDTH +: PSUM_WIDTH] <= acc[k];
        end
      end else begin
        drain_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
    end else begin
      if (o_in_rdy && (i_data_vld != i_weight_vld)) err_q[0] <= 1'b1;
      if (!o_in_rdy && i_data_vld && i_weight_vld)  err_q[1] <= 1'b1;
    end
  end

  assign err_psum_vld = {{(REG_WIDTH-2){1'b0}}, err_q};

endmodule

// File: tb/tb_kernel_channel_acc_pe.sv
// Directed bench for kernel_channel_acc_pe: stimulus pushes expected psums, a monitor checks handshakes.
module tb_kernel_channel_acc_pe;

  localparam int DW = 24;
  localparam int WW = 96;
  localparam int PW = 96;

  logic          clk;
  logic          rst;
  logic [DW-1:0] i_data;
  logic          i_data_vld;
  logic [WW-1:0] i_weight;
  logic          i_weight_vld;
  logic [PW-1:0] i_psum;
  logic          i_conf_neg_enb;
  logic [7:0]    i_conf_acc_len;
  logic          o_in_rdy;
  logic [PW-1:0] o_psum;
  logic          o_psum_vld;
  logic          i_psum_rdy;
  logic [31:0]   err_psum_vld;

  kernel_channel_acc_pe dut (
    .clk            (clk),
    .rst            (rst),
    .i_data         (i_data),
    .i_data_vld     (i_data_vld),
    .i_weight       (i_weight),
    .i_weight_vld   (i_weight_vld),
    .i_psum         (i_psum),
    .i_conf_neg_enb (i_conf_neg_enb),
    .i_conf_acc_len (i_conf_acc_len),
    .o_in_rdy       (o_in_rdy),
    .o_psum         (o_psum),
    .o_psum_vld     (o_psum_vld),
    .i_psum_rdy     (i_psum_rdy),
    .err_psum_vld   (err_psum_vld)
  );

  int            n_checks = 0;
  int            n_fail   = 0;
  int            n_push   = 0;
  int            n_pop    = 0;
  logic [PW-1:0] sb [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every output handshake must match the oldest expected group.
  initial begin
    logic [PW-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst && o_psum_vld && i_psum_rdy) begin
        n_pop++;
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_psum: got %0h, expected no output", o_psum);
        end else begin
          e = sb.pop_front();
          check("psum", o_psum, e);
        end
      end
    end
  end

  task automatic send_beat(input logic [DW-1:0] d, input logic [WW-1:0] w, input logic [PW-1:0] p,
                           input logic neg, input logic [7:0] len);
    int i;
    i_data = d; i_weight = w; i_psum = p;
    i_conf_neg_enb = neg; i_conf_acc_len = len;
    i_data_vld = 1'b1; i_weight_vld = 1'b1;
    i = 0;
    while (!o_in_rdy && i < 50) begin
      @(posedge clk); #1;
      i++;
    end
    if (!o_in_rdy) check("beat_rdy_timeout", o_in_rdy, 1'b1);
    @(posedge clk); #1;
    i_data_vld = 1'b0; i_weight_vld = 1'b0;
  endtask

  // Returns cycles from the final accept edge until o_psum_vld is seen; counts o_in_rdy highs.
  task automatic wait_vld(output int lat, output int rdy_hi);
    lat = -1;
    rdy_hi = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (o_in_rdy) rdy_hi++;
      if (o_psum_vld) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic wait_done();
    int i;
    i = 0;
    while (o_psum_vld && i < 50) begin
      @(posedge clk); #1;
      i++;
    end
    if (o_psum_vld) check("done_timeout", o_psum_vld, 1'b0);
  endtask

  task automatic run_group(input logic [DW-1:0] d, input logic [WW-1:0] w, input logic [PW-1:0] p,
                           input logic neg, input int len, input int gap, input logic [PW-1:0] exp,
                           output int lat, output int rdy_hi);
    sb.push_back(exp);
    n_push++;
    for (int b = 0; b < len; b++) begin
      send_beat(d, w, p, neg, 8'(len));
      if (b != len-1) repeat (gap) begin @(posedge clk); #1; end
    end
    wait_vld(lat, rdy_hi);
  endtask

  localparam logic [WW-1:0] W_T1  = {24'hFFFFFF, 24'h000000, 24'h020202, 24'h010101};
  localparam logic [PW-1:0] P_T1  = {24'd0, 24'd0, 24'd0, 24'd10};
  localparam logic [PW-1:0] E_T1  = {24'd1530, 24'd0, 24'd12, 24'd16};
  localparam logic [PW-1:0] P_BP  = {24'd0, 24'd0, 24'd0, 24'd100};
  localparam logic [PW-1:0] E_BP  = {24'd1530, 24'd0, 24'd12, 24'd106};

  initial begin
    int lat, rdy_hi;
    rst = 1'b1;
    i_data = '0; i_data_vld = 1'b0; i_weight = '0; i_weight_vld = 1'b0;
    i_psum = '0; i_conf_neg_enb = 1'b0; i_conf_acc_len = '0; i_psum_rdy = 1'b1;
    #3;
    check("rst_psum", o_psum, '0);
    check("rst_vld", o_psum_vld, 1'b0);
    check("rst_in_rdy", o_in_rdy, 1'b0);
    check("rst_err", err_psum_vld, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("idle_in_rdy", o_in_rdy, 1'b1);

    // Unsigned single-beat group.
    run_group(24'h030201, W_T1, P_T1, 1'b0, 1, 0, E_T1, lat, rdy_hi);
    check("lat_unsigned", lat, 4);
    wait_done();

    // Signed: (-1)*2 over 3 channels on a -4 bias.
    run_group(24'hFFFFFF, {12{8'h02}}, {4{24'hFFFFFC}}, 1'b1, 1, 0, {4{24'hFFFFF6}}, lat, rdy_hi);
    check("lat_signed", lat, 4);
    wait_done();

    // Four beats with idle gaps; input side must stay closed until the handshake.
    run_group(24'h010203, {12{8'h01}}, {4{24'd5}}, 1'b0, 4, 1, {4{24'd29}}, lat, rdy_hi);
    check("lat_len4", lat, 4);
    check("in_rdy_drain", rdy_hi, 0);
    check("in_rdy_out", o_in_rdy, 1'b0);
    wait_done();

    // Modular wrap over 100 beats.
    run_group(24'hFFFFFF, {12{8'hFF}}, '0, 1'b0, 100, 0, {4{24'd2730284}}, lat, rdy_hi);
    check("lat_wrap", lat, 4);
    wait_done();

    // Backpressure: hold off the handshake and inject a beat that must be dropped.
    i_psum_rdy = 1'b0;
    run_group(24'h030201, W_T1, P_BP, 1'b0, 1, 0, E_BP, lat, rdy_hi);
    check("lat_bp", lat, 4);
    for (int i = 0; i < 5; i++) begin
      check("bp_vld", o_psum_vld, 1'b1);
      check("bp_psum", o_psum, E_BP);
      if (i == 1) begin
        i_data = 24'hFFFFFF; i_weight = {12{8'hFF}};
        i_data_vld = 1'b1; i_weight_vld = 1'b1;
      end else begin
        i_data_vld = 1'b0; i_weight_vld = 1'b0;
      end
      @(posedge clk); #1;
    end
    i_data_vld = 1'b0; i_weight_vld = 1'b0;
    check("err_dropped", err_psum_vld, 32'h2);
    i_psum_rdy = 1'b1;
    @(posedge clk); #1;
    wait_done();

    // Mismatched valids while the input side is open.
    i_data_vld = 1'b1; i_weight_vld = 1'b0;
    @(posedge clk); #1;
    i_data_vld = 1'b0;
    check("err_mismatch", err_psum_vld, 32'h3);

    // Asynchronous reset in the middle of an accumulation.
    send_beat(24'hFFFFFF, {12{8'hFF}}, {4{24'd77}}, 1'b0, 8'd4);
    send_beat(24'hFFFFFF, {12{8'hFF}}, {4{24'd77}}, 1'b0, 8'd4);
    #3 rst = 1'b1;
    #1;
    check("arst_psum", o_psum, '0);
    check("arst_vld", o_psum_vld, 1'b0);
    check("arst_in_rdy", o_in_rdy, 1'b0);
    check("arst_err", err_psum_vld, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;

    run_group(24'h030201, W_T1, P_T1, 1'b0, 1, 0, E_T1, lat, rdy_hi);
    check("lat_after_rst", lat, 4);
    wait_done();

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", n_pop, n_push);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
